// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder_accum_n unit.
// Op encoding and signed saturation limits (up to 16 bits).
package adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  localparam int MAX_W = 16;

  // Largest positive signed value for a w-bit word.
  function automatic logic [MAX_W-1:0] sat_pos(input int w);
    return MAX_W'((1 << (w - 1)) - 1);
  endfunction

  // Most negative signed value for a w-bit word.
  function automatic logic [MAX_W-1:0] sat_neg(input int w);
    return MAX_W'(1 << (w - 1));
  endfunction

endpackage

// File: rtl/adder_core_n.sv
// Combinational WIDTH-bit add/subtract with carry and overflow.
// Ports: a, b, sub in; sum, carry (borrow on sub), overflow out.
// Optional ADDER_SAT_EN: signed saturation of sum on overflow.
module adder_core_n
  import adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   raw;

  assign b_eff = sub ? ~b : b;
  assign raw   = {1'b0, a} + {1'b0, b_eff}
               + (WIDTH+1)'(sub);

  // Carry out is inverted into an active-high borrow for sub.
  assign carry = sub ? ~raw[WIDTH] : raw[WIDTH];

  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1])
                 && (raw[WIDTH-1] != a[WIDTH-1]);

`ifdef ADDER_SAT_EN
  localparam logic [MAX_W-1:0] P16 = sat_pos(WIDTH);
  localparam logic [MAX_W-1:0] N16 = sat_neg(WIDTH);
  localparam logic [WIDTH-1:0] SAT_P = P16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_N = N16[WIDTH-1:0];

  // Overflow only happens with equal operand signs,
  // so a's sign tells the direction.
  always_comb begin
    sum = raw[WIDTH-1:0];
    if (overflow)
      sum = a[WIDTH-1] ? SAT_N : SAT_P;
  end
`else
  assign sum = raw[WIDTH-1:0];
`endif

endmodule

// File: rtl/adder_accum_n.sv
// Add/sub/accumulate unit with valid/ready in and out, 1-cycle latency.
// Ports: clk, rst (async high), in_valid/in_ready, op, a, b,
//   out_valid/out_ready, result, carry, overflow, acc, op_count.
// Optional ADDER_SAT_EN: signed saturation for ADD, SUB and ACC.
module adder_accum_n
  import adder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  logic             accept;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic             core_sub;
  logic [WIDTH-1:0] core_sum;
  logic             core_c;
  logic             core_o;
  logic [WIDTH-1:0] nxt_res;
  logic             nxt_c;
  logic             nxt_o;
  logic [WIDTH-1:0] nxt_acc;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  adder_core_n #(
    .WIDTH(WIDTH)
  ) u_core (
    .a       (core_a),
    .b       (core_b),
    .sub     (core_sub),
    .sum     (core_sum),
    .carry   (core_c),
    .overflow(core_o)
  );

  // ACC routes the accumulator into the A leg and the a operand into B.
  always_comb begin
    core_a   = a;
    core_b   = b;
    core_sub = 1'b0;
    nxt_res  = core_sum;
    nxt_c    = core_c;
    nxt_o    = core_o;
    nxt_acc  = acc;
    unique case (1'b1)
      (op == OP_ADD): ;
      (op == OP_SUB): core_sub = 1'b1;
      (op == OP_ACC): begin
        core_a  = acc;
        core_b  = a;
        nxt_acc = core_sum;
      end
      (op == OP_CLR): begin
        nxt_res = '0;
        nxt_c   = 1'b0;
        nxt_o   = 1'b0;
        nxt_acc = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      acc       <= '0;
      op_count  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= nxt_res;
      carry     <= nxt_c;
      overflow  <= nxt_o;
      acc       <= nxt_acc;
      op_count  <= op_count + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_accum_n.sv
// Self-checking bench for adder_accum_n (WIDTH=4, CNT_W=8).
// Directed steps then randomized traffic against an integer model.
module tb_adder_accum_n;

  localparam int W     = 4;
  localparam int CW    = 8;
  localparam int M     = 1 << W;
  localparam int CM    = 1 << CW;
  localparam int MAXS  = (M / 2) - 1;
  localparam int MINS  = -(M / 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry;
  logic          overflow;
  logic [W-1:0]  acc;
  logic [CW-1:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  int m_valid, m_res, m_carry, m_ovf, m_acc, m_cnt;
  bit last_taken;

  always #5 clk = ~clk;

  adder_accum_n #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .acc      (acc),
    .op_count (op_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_res   = 0;
    m_carry = 0;
    m_ovf   = 0;
    m_acc   = 0;
    m_cnt   = 0;
  endtask

  // Arithmetic on plain integers, following the operation definitions.
  task automatic model_op(input int o, input int x, input int y);
    int s, ss, r;
    bit ov;
    s  = 0;
    ss = 0;
    case (o)
      0: begin
        s = x + y;
        ss = sx(x) + sx(y);
        m_carry = (s >= M);
      end
      1: begin
        s = x - y;
        ss = sx(x) - sx(y);
        m_carry = (x < y);
      end
      2: begin
        s = m_acc + x;
        ss = sx(m_acc) + sx(x);
        m_carry = (s >= M);
      end
      default: begin
        m_carry = 0;
      end
    endcase
    r  = ((s % M) + M) % M;
    ov = (o != 3) && (ss > MAXS || ss < MINS);
`ifdef ADDER_SAT_EN
    if (ov) r = (ss > MAXS) ? MAXS : MINS + M;
`endif
    m_res = r;
    m_ovf = ov;
    if (o == 2) m_acc = r;
    if (o == 3) m_acc = 0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_out_valid"}, out_valid, m_valid);
    chk({tag, "_result"},    result,    m_res);
    chk({tag, "_carry"},     carry,     m_carry);
    chk({tag, "_overflow"},  overflow,  m_ovf);
    chk({tag, "_acc"},       acc,       m_acc);
    chk({tag, "_op_count"},  op_count,  m_cnt);
  endtask

  // Inputs are driven just after a rising edge; one clock is then run.
  task automatic cycle(input string tag);
    bit rdy;
    #1;
    rdy = !m_valid || out_ready;
    chk({tag, "_in_ready"}, in_ready, rdy);
    last_taken = in_valid && rdy;
    if (last_taken) begin
      model_op(op, a, b);
      m_valid = 1;
      m_cnt = (m_cnt + 1) % CM;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk_outs(tag);
  endtask

  task automatic drive(input int o, input int x, input int y);
    in_valid = 1'b1;
    op = 2'(o);
    a  = W'(x);
    b  = W'(y);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 2'd0;
    a = '0;
    b = '0;
    last_taken = 0;
    model_reset();
    #12;
    chk_outs("reset");
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    drive(0, 7, 9);
    cycle("add_7_9");
    chk("add_7_9_const_result", result, 0);
    chk("add_7_9_const_carry", carry, 1);
    drive(1, 3, 5);
    cycle("sub_3_5");
    drive(1, 8, 1);
    cycle("sub_8_1");

    drive(3, 0, 0);
    cycle("clr");
    for (int i = 0; i < 4; i++) begin
      drive(2, 5, $urandom_range(0, M - 1));
      cycle("acc_5");
    end
    drive(0, 1, 2);
    cycle("add_after_acc");

    drive(3, 0, 0);
    cycle("clr2");
    out_ready = 1'b0;
    drive(2, 9, 0);
    cycle("acc_9");
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_outs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    drive(0, 2, 3);
    cycle("bp_first");
    for (int i = 0; i < 3; i++) cycle("bp_hold");
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(i % 3, $urandom_range(0, M - 1),
            $urandom_range(0, M - 1));
      cycle("stream");
    end

    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && !last_taken)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op = 2'($urandom_range(0, 3));
        a  = W'($urandom_range(0, M - 1));
        b  = W'($urandom_range(0, M - 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
